// File: rtl/vga_rx_monitor_if.sv
// Video input and monitor result bundle for vga_rx_monitor.
// The master side drives the video stream; the slave side is the monitor.
interface vga_rx_monitor_if;
   logic        hs;
   logic        vs;
   logic        blank_n;
   logic [7:0]  b;
   logic [7:0]  g;
   logic [7:0]  r;
   logic        clr_err;
   logic        de;
   logic [9:0]  x;
   logic [9:0]  y;
   logic [23:0] pix;
   logic [10:0] h_meas;
   logic [10:0] v_meas;
   logic [15:0] frame_cnt;
   logic        locked;
   logic        err;
   logic [15:0] frame_crc;
   logic        crc_valid;

   modport master (
      output hs, vs, blank_n, b, g, r, clr_err,
      input  de, x, y, pix, h_meas, v_meas, frame_cnt, locked, err, frame_crc, crc_valid
   );

   modport slave (
      input  hs, vs, blank_n, b, g, r, clr_err,
      output de, x, y, pix, h_meas, v_meas, frame_cnt, locked, err, frame_crc, crc_valid
   );
endinterface

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: pixel coordinates, timing measurement and lock tracking.
// Define VGA_RX_MONITOR_CRC_EN to add a per-frame CRC-16-CCITT over active pixels.
module vga_rx_monitor #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input logic             iVGA_CLK,
   input logic             iRST_n,
   vga_rx_monitor_if.slave vid
);
   localparam int unsigned CW = 11;
   localparam int unsigned GW = 16;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

   function automatic logic [9:0] sat10(input logic [CW-1:0] v);
      return v[CW-1] ? 10'h3FF : v[9:0];
   endfunction

   logic          hs_s1, vs_s1, de_s1, clr_s1;
   logic [23:0]   pix_s1;
   logic          hs_d, vs_d, de_d;
   logic          hs_fall, vs_fall, de_fall;
   logic [CW-1:0] pix_cnt, line_cnt;
   logic          frame_bad, h_bad, hs_in_de, frame_good;
   state_t        state, state_nxt;
   logic [GW-1:0] good_cnt, good_nxt;
   logic          err_set;

   // Stage 1 input capture plus one-cycle history for edge detection
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         hs_s1  <= 1'b0;
         vs_s1  <= 1'b0;
         de_s1  <= 1'b0;
         clr_s1 <= 1'b0;
         pix_s1 <= '0;
         hs_d   <= 1'b0;
         vs_d   <= 1'b0;
         de_d   <= 1'b0;
      end else begin
         hs_s1  <= vid.hs;
         vs_s1  <= vid.vs;
         de_s1  <= vid.blank_n;
         clr_s1 <= vid.clr_err;
         pix_s1 <= {vid.b, vid.g, vid.r};
         hs_d   <= hs_s1;
         vs_d   <= vs_s1;
         de_d   <= de_s1;
      end
   end

   assign hs_fall = hs_d & ~hs_s1;
   assign vs_fall = vs_d & ~vs_s1;
   assign de_fall = de_d & ~de_s1;

   // Any violation seen in this cycle counts toward the frame being judged now
   assign h_bad      = de_fall && (pix_cnt != CW'(H_ACTIVE));
   assign hs_in_de   = hs_fall && de_s1;
   assign frame_good = !(frame_bad || h_bad || hs_in_de) && (line_cnt == CW'(V_ACTIVE));

   // Counters are wider than oX/oY so the measurements stay exact beyond 1023
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         pix_cnt   <= '0;
         line_cnt  <= '0;
         frame_bad <= 1'b0;
      end else begin
         if (hs_fall)
            pix_cnt <= '0;
         else if (de_s1 && pix_cnt != CNT_MAX)
            pix_cnt <= pix_cnt + CW'(1);

         if (vs_fall)
            line_cnt <= '0;
         else if (de_fall && line_cnt != CNT_MAX)
            line_cnt <= line_cnt + CW'(1);

         if (vs_fall)
            frame_bad <= 1'b0;
         else if (h_bad || hs_in_de)
            frame_bad <= 1'b1;
      end
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state    <= SEARCH;
         good_cnt <= '0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_nxt;
      end
   end

   // Frames are judged only at VS fall; the frame that brought us out of SEARCH is skipped
   always_comb begin
      state_nxt = state;
      good_nxt  = good_cnt;
      err_set   = 1'b0;
      case (state)
         SEARCH: begin
            if (vs_fall) begin
               state_nxt = MEASURE;
               good_nxt  = '0;
            end
         end
         MEASURE: begin
            if (vs_fall) begin
               if (frame_good) begin
                  good_nxt = good_cnt + GW'(1);
                  if ((good_cnt + GW'(1)) >= GW'(LOCK_FRAMES))
                     state_nxt = LOCKED;
               end else begin
                  good_nxt = '0;
               end
            end
         end
         LOCKED: begin
            if (vs_fall && !frame_good) begin
               state_nxt = SEARCH;
               err_set   = 1'b1;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   // Stage 2 outputs
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         vid.de        <= 1'b0;
         vid.x         <= '0;
         vid.y         <= '0;
         vid.pix       <= '0;
         vid.h_meas    <= '0;
         vid.v_meas    <= '0;
         vid.frame_cnt <= '0;
         vid.locked    <= 1'b0;
         vid.err       <= 1'b0;
      end else begin
         vid.de     <= de_s1;
         vid.x      <= sat10(pix_cnt);
         vid.y      <= sat10(line_cnt);
         vid.pix    <= pix_s1;
         vid.locked <= (state_nxt == LOCKED);
         if (de_fall)
            vid.h_meas <= pix_cnt;
         if (vs_fall) begin
            vid.v_meas    <= line_cnt;
            vid.frame_cnt <= vid.frame_cnt + 16'd1;
         end
         if (err_set)
            vid.err <= 1'b1;
         else if (clr_s1)
            vid.err <= 1'b0;
      end
   end

`ifdef VGA_RX_MONITOR_CRC_EN
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 23; i >= 0; i--) begin
         if (r[15] ^ d[i])
            r = (r << 1) ^ 16'h1021;
         else
            r = r << 1;
      end
      return r;
   endfunction

   logic [15:0] crc_q, crc_nxt;

   assign crc_nxt = de_s1 ? crc_step(crc_q, pix_s1) : crc_q;

   // Result is taken before the restart so a pixel in the VS-fall cycle is not lost
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         crc_q         <= 16'hFFFF;
         vid.frame_crc <= '0;
         vid.crc_valid <= 1'b0;
      end else begin
         vid.crc_valid <= vs_fall;
         if (vs_fall) begin
            vid.frame_crc <= crc_nxt;
            crc_q         <= 16'hFFFF;
         end else begin
            crc_q <= crc_nxt;
         end
      end
   end
`else
   assign vid.frame_crc = '0;
   assign vid.crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Self-checking bench for vga_rx_monitor on a scaled-down raster (8x4 active, 14x7 total).
// Expected outputs come from a cycle-level reference model delayed two cycles through a queue.
module tb_vga_rx_monitor;
   localparam int unsigned H_ACT = 8;
   localparam int unsigned V_ACT = 4;
   localparam int unsigned LOCKF = 2;
   localparam int unsigned H_TOT = 14;
   localparam int unsigned V_TOT = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vga_rx_monitor_if bus ();

   vga_rx_monitor #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .LOCK_FRAMES(LOCKF)) dut (
      .iVGA_CLK (clk),
      .iRST_n   (rst_n),
      .vid      (bus)
   );

   typedef struct {
      logic        de;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [23:0] pix;
      logic [10:0] hm;
      logic [10:0] vm;
      logic [15:0] fc;
      logic        lk;
      logic        er;
      logic [15:0] crc;
      logic        cv;
   } exp_t;

   exp_t        q[$];
   exp_t        cur;
   int          xc, yc, run;
   bit          p_hs, p_vs, p_de, bad, synced, lk;
   logic [15:0] crc_run;
   bit          clr_at_vs;
   int          tests = 0;
   int          fails = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Byte-wise CRC-16-CCITT, bytes taken B then G then R
   function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [23:0] px);
      logic [15:0] c;
      logic [23:0] v;
      c = c_in;
      v = px;
      for (int k = 0; k < 3; k++) begin
         c = c ^ {v[23:16], 8'h00};
         v = v << 8;
         for (int j = 0; j < 8; j++)
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

   function automatic logic [9:0] sat10(input int v);
      return (v > 1023) ? 10'd1023 : 10'(v);
   endfunction

   task automatic model_reset();
      xc = 0; yc = 0; run = 0;
      p_hs = 0; p_vs = 0; p_de = 0;
      bad = 0; synced = 0; lk = 0;
      crc_run = 16'hFFFF;
      cur = '{default: '0};
      q.delete();
      q.push_back(cur);
   endtask

   // One input cycle of the reference behaviour
   task automatic model(input bit hs, input bit vs, input bit de, input logic [23:0] px, input bit clr);
      bit hs_f, vs_f, de_f, good, set;
      int y_old;
      hs_f  = p_hs && !hs;
      vs_f  = p_vs && !vs;
      de_f  = p_de && !de;
      y_old = yc;
      set   = 0;
      cur.de  = de;
      cur.pix = px;
      cur.x   = sat10(xc);
      cur.y   = sat10(yc);
      cur.cv  = 0;
      if (de_f) begin
         cur.hm = (xc > 2047) ? 11'd2047 : 11'(xc);
         if (xc != H_ACT) bad = 1;
         yc++;
      end
      if (hs_f && de) bad = 1;
      if (hs_f) xc = 0;
      else if (de) xc++;
      if (de) crc_run = crc_ref(crc_run, px);
      if (vs_f) begin
         cur.vm = 11'(y_old);
         cur.fc = cur.fc + 16'd1;
         good   = !bad && (y_old == V_ACT);
         if (!synced) begin
            synced = 1; run = 0;
         end else if (!lk) begin
            if (good) begin
               run++;
               if (run >= LOCKF) lk = 1;
            end else run = 0;
         end else if (!good) begin
            lk = 0; synced = 0; set = 1;
         end
`ifdef VGA_RX_MONITOR_CRC_EN
         cur.crc = crc_run;
         cur.cv  = 1;
`endif
         crc_run = 16'hFFFF;
         bad = 0;
         yc  = 0;
      end
      cur.lk = lk;
      if (set) cur.er = 1;
      else if (clr) cur.er = 0;
      p_hs = hs; p_vs = vs; p_de = de;
   endtask

   task automatic compare(input exp_t e);
      chk("oDE", 32'(bus.de), 32'(e.de));
      if (e.de) begin
         chk("oX", 32'(bus.x), 32'(e.x));
         chk("oY", 32'(bus.y), 32'(e.y));
         chk("oPIX", 32'(bus.pix), 32'(e.pix));
      end
      chk("oH_MEAS", 32'(bus.h_meas), 32'(e.hm));
      chk("oV_MEAS", 32'(bus.v_meas), 32'(e.vm));
      chk("oFRAME_CNT", 32'(bus.frame_cnt), 32'(e.fc));
      chk("oLOCKED", 32'(bus.locked), 32'(e.lk));
      chk("oERR", 32'(bus.err), 32'(e.er));
      chk("oFRAME_CRC", 32'(bus.frame_crc), 32'(e.crc));
      chk("oCRC_VALID", 32'(bus.crc_valid), 32'(e.cv));
   endtask

   // Drive one cycle just after a rising edge, then check the output due two edges after its input
   task automatic step(input bit hs, input bit vs, input bit de, input logic [23:0] px, input bit clr);
      bus.hs = hs; bus.vs = vs; bus.blank_n = de; bus.clr_err = clr;
      bus.b = px[23:16]; bus.g = px[15:8]; bus.r = px[7:0];
      model(hs, vs, de, px, clr);
      q.push_back(cur);
      @(posedge clk);
      #1;
      compare(q.pop_front());
   endtask

   task automatic send_line(input int ln, input int act, input int c0, input int c1,
                            input bit rnd, input logic [23:0] cpx);
      for (int c = c0; c < c1; c++)
         step(!(c >= 10 && c < 12), ln != 5, (ln < 4) && (c < act),
              rnd ? 24'($urandom) : cpx, clr_at_vs && ln == 5 && c == 0);
   endtask

   task automatic send_frame(input int short_ln, input bit rnd, input logic [23:0] cpx);
      for (int ln = 0; ln < int'(V_TOT); ln++)
         send_line(ln, (ln == short_ln) ? H_ACT - 1 : H_ACT, 0, H_TOT, rnd, cpx);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst oDE", 32'(bus.de), 32'd0);
      chk("rst oX", 32'(bus.x), 32'd0);
      chk("rst oY", 32'(bus.y), 32'd0);
      chk("rst oPIX", 32'(bus.pix), 32'd0);
      chk("rst oH_MEAS", 32'(bus.h_meas), 32'd0);
      chk("rst oV_MEAS", 32'(bus.v_meas), 32'd0);
      chk("rst oFRAME_CNT", 32'(bus.frame_cnt), 32'd0);
      chk("rst oLOCKED", 32'(bus.locked), 32'd0);
      chk("rst oERR", 32'(bus.err), 32'd0);
      chk("rst oFRAME_CRC", 32'(bus.frame_crc), 32'd0);
      chk("rst oCRC_VALID", 32'(bus.crc_valid), 32'd0);
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   logic [15:0] zero_crc;

   initial begin
      bus.hs = 1'b1; bus.vs = 1'b1; bus.blank_n = 1'b0; bus.clr_err = 1'b0;
      bus.b = '0; bus.g = '0; bus.r = '0;
      clr_at_vs = 0;
      zero_crc = 16'hFFFF;
      for (int i = 0; i < int'(H_ACT * V_ACT); i++) zero_crc = crc_ref(zero_crc, 24'h0);

      // Lock after three frames
      do_reset(3);
      repeat (3) send_frame(-1, 1, 24'h0);
      chk("lock oLOCKED", 32'(bus.locked), 32'd1);
      chk("lock oH_MEAS", 32'(bus.h_meas), H_ACT);
      chk("lock oV_MEAS", 32'(bus.v_meas), V_ACT);
      chk("lock oERR", 32'(bus.err), 32'd0);
      chk("lock oFRAME_CNT", 32'(bus.frame_cnt), 32'd3);

      // One short line while locked drops lock and raises the error
      send_frame($urandom_range(0, 3), 1, 24'h0);
      chk("short oLOCKED", 32'(bus.locked), 32'd0);
      chk("short oERR", 32'(bus.err), 32'd1);
      chk("short oH_MEAS", 32'(bus.h_meas), H_ACT);
      step(1, 1, 0, 24'h0, 1);
      step(1, 1, 0, 24'h0, 0);
      chk("clr oERR", 32'(bus.err), 32'd0);

      // Relock, then a bad frame with a clear pulse in the same cycle: set wins
      repeat (3) send_frame(-1, 1, 24'h0);
      chk("relock oLOCKED", 32'(bus.locked), 32'd1);
      clr_at_vs = 1;
      send_frame(1, 1, 24'h0);
      clr_at_vs = 0;
      chk("setwins oERR", 32'(bus.err), 32'd1);
      step(1, 1, 0, 24'h0, 1);
      step(1, 1, 0, 24'h0, 0);
      chk("clr2 oERR", 32'(bus.err), 32'd0);

      // Two constant-black frames produce the same known CRC
      send_frame(-1, 0, 24'h0);
`ifdef VGA_RX_MONITOR_CRC_EN
      chk("crc frame1", 32'(bus.frame_crc), 32'(zero_crc));
`else
      chk("crc frame1", 32'(bus.frame_crc), 32'd0);
`endif
      send_frame(-1, 0, 24'h0);
`ifdef VGA_RX_MONITOR_CRC_EN
      chk("crc frame2", 32'(bus.frame_crc), 32'(zero_crc));
`else
      chk("crc frame2", 32'(bus.frame_crc), 32'd0);
`endif

      // Reset in the middle of an active line, then reacquire lock
      send_line(0, H_ACT, 0, H_TOT, 1, 24'h0);
      send_line(1, H_ACT, 0, H_TOT, 1, 24'h0);
      send_line(2, H_ACT, 0, 5, 1, 24'h0);
      do_reset(2);
      send_line(2, H_ACT, 5, H_TOT, 1, 24'h0);
      for (int ln = 3; ln < int'(V_TOT); ln++) send_line(ln, H_ACT, 0, H_TOT, 1, 24'h0);
      chk("mid oLOCKED", 32'(bus.locked), 32'd0);
      chk("mid oERR", 32'(bus.err), 32'd0);
      repeat (LOCKF) send_frame(-1, 1, 24'h0);
      chk("reacq oLOCKED", 32'(bus.locked), 32'd1);
      chk("reacq oERR", 32'(bus.err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
